// File: rtl/window_scanner_pkg.sv
// ----------------------------------------------------------------------------
// cnn_buf_pkg
// Geometry constants shared by the feature-map buffer, its loader and the
// window scanner, plus the scanner state encoding.
//   IMG_DIM  : buffer side length in bytes
//   WIN      : window side length (window = WIN*WIN bytes)
//   DW       : byte width
//   npos()   : window positions per axis for a given stride
// ----------------------------------------------------------------------------
package cnn_buf_pkg;

   localparam int unsigned IMG_DIM   = 13;
   localparam int unsigned WIN       = 4;
   localparam int unsigned DW        = 8;
   localparam int unsigned WIN_BYTES = WIN * WIN;
   localparam int unsigned WIN_BITS  = WIN_BYTES * DW;
   localparam int unsigned OFF_W     = 4;
   localparam int unsigned POS_SPAN  = IMG_DIM - WIN;

   // Positions per axis; STRIDE is restricted to values that divide POS_SPAN.
   function automatic int unsigned npos(input int unsigned stride);
      return (POS_SPAN / stride) + 1;
   endfunction

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      HOLD    = 3'd3,
      DONE    = 3'd4
   } scan_state_t;

endpackage

// File: rtl/window_scanner_if.sv
// ----------------------------------------------------------------------------
// window_scanner_if
// Window handshake between the scanner (master) and the PE array (slave).
//   win_out   : captured window, byte n at [n*DW +: DW], n = WIN*i + j
//   win_valid : win_out holds a window not yet accepted
//   win_last  : qualifies win_valid; final window of the scan
//   win_ready : downstream accepts when win_valid && win_ready
// ----------------------------------------------------------------------------
interface window_scanner_if;
   import cnn_buf_pkg::*;

   logic [WIN_BITS-1:0] win_out;
   logic                win_valid;
   logic                win_last;
   logic                win_ready;

   modport master (
      output win_out,
      output win_valid,
      output win_last,
      input  win_ready
   );

   modport slave (
      input  win_out,
      input  win_valid,
      input  win_last,
      output win_ready
   );

endinterface

// File: rtl/window_scanner_pos_counter_2d.sv
// ----------------------------------------------------------------------------
// pos_counter_2d
// Row-major (k outer, q inner) window-offset counter stepping by STRIDE over
// 0..IMG_DIM-WIN on both axes.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return to (0,0)
//   adv      : step to the next position
//   k, q     : current row / column offset (registered)
//   at_last  : current position is the final one (registered)
// ----------------------------------------------------------------------------
module pos_counter_2d
   import cnn_buf_pkg::*;
#(
   parameter int unsigned STRIDE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [OFF_W-1:0] k,
   output logic [OFF_W-1:0] q,
   output logic             at_last
);

   localparam int unsigned NPOS     = npos(STRIDE);
   localparam int unsigned LAST_OFF = (NPOS - 1) * STRIDE;

   logic [OFF_W-1:0] k_nxt_c;
   logic [OFF_W-1:0] q_nxt_c;

   // Next position: wrap q at the row end and step k.
   always_comb begin
      k_nxt_c = k;
      q_nxt_c = q + OFF_W'(STRIDE);
      if (q == OFF_W'(LAST_OFF)) begin
         q_nxt_c = '0;
         k_nxt_c = k + OFF_W'(STRIDE);
      end
   end

   // Offset registers; at_last is precomputed so it is valid with k/q.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         k       <= '0;
         q       <= '0;
         at_last <= 1'b0;
      end else if (adv) begin
         k       <= k_nxt_c;
         q       <= q_nxt_c;
         at_last <= (k_nxt_c == OFF_W'(LAST_OFF)) && (q_nxt_c == OFF_W'(LAST_OFF));
      end
   end

endmodule

// File: rtl/window_scanner.sv
// ----------------------------------------------------------------------------
// window_scanner
// Read-side controller for the 13x13 feature-map buffer. Sweeps every legal
// 4x4 window offset in row-major order, captures the buffer's registered
// window output and hands each window downstream over valid/ready.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, begins a scan when idle
//   k, q       : window offset to the buffer
//   win_in     : buffer dataOut (registered, READ_LAT cycles after k/q)
//   win        : window handshake (master side)
//   busy       : scan in progress
//   done       : one-cycle pulse after the last window is accepted
//   perf_stall : cycles with win_valid && !win_ready, saturating
//                (present only with WINDOW_SCANNER_PERF_EN defined)
// ----------------------------------------------------------------------------
module window_scanner
   import cnn_buf_pkg::*;
#(
   parameter int unsigned STRIDE   = 1,
   parameter int unsigned READ_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [OFF_W-1:0]    k,
   output logic [OFF_W-1:0]    q,
   input  logic [WIN_BITS-1:0] win_in,
   window_scanner_if.master    win,
   output logic                busy,
   output logic                done
`ifdef WINDOW_SCANNER_PERF_EN
   ,
   output logic [15:0]         perf_stall
`endif
);

   localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   scan_state_t      state;
   logic [CNT_W-1:0] wait_cnt;
   logic             at_last;
   logic             start_acc_c;
   logic             hs_c;
   logic             adv_c;

   assign start_acc_c = (state == IDLE) && start;
   assign hs_c        = win.win_valid && win.win_ready;
   assign adv_c       = (state == HOLD) && hs_c && !win.win_last;

   // Offsets only move on an accepted start or a non-final handshake.
   pos_counter_2d #(
      .STRIDE (STRIDE)
   ) u_pos (
      .clk     (clk),
      .rst     (rst),
      .clr     (start_acc_c),
      .adv     (adv_c),
      .k       (k),
      .q       (q),
      .at_last (at_last)
   );

   // Scan sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         win.win_out   <= '0;
         win.win_valid <= 1'b0;
         win.win_last  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ISSUE;
                  busy     <= 1'b1;
                  wait_cnt <= '0;
               end
            end
            // Hold k/q while the buffer registers the window.
            ISSUE: begin
               if (wait_cnt == CNT_W'(READ_LAT - 1)) begin
                  state <= CAPTURE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            CAPTURE: begin
               win.win_out   <= win_in;
               win.win_valid <= 1'b1;
               win.win_last  <= at_last;
               state         <= HOLD;
            end
            // win_valid is always high here, so win_ready alone is the handshake.
            HOLD: begin
               if (win.win_ready) begin
                  win.win_valid <= 1'b0;
                  wait_cnt      <= '0;
                  if (win.win_last) begin
                     win.win_last <= 1'b0;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     state        <= DONE;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef WINDOW_SCANNER_PERF_EN
   // Backpressure cycle counter; restarts with each accepted scan.
   always_ff @(posedge clk) begin
      if (rst || start_acc_c) begin
         perf_stall <= '0;
      end else if (win.win_valid && !win.win_ready && (perf_stall != 16'hFFFF)) begin
         perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_window_scanner.sv
// ----------------------------------------------------------------------------
// tb_window_scanner
// Two scanners (STRIDE 1 and STRIDE 3) share one clock, reset and a
// behavioural 13x13 buffer. Expected windows are queued per scan start and
// popped by a monitor on each handshake.
// ----------------------------------------------------------------------------
module tb_window_scanner;
   import cnn_buf_pkg::*;

   typedef struct packed {
      logic [3:0]          k;
      logic [3:0]          q;
      logic                last;
      logic [WIN_BITS-1:0] data;
   } exp_t;

   logic clk;
   logic rst;
   logic [1:0] start_s;
   logic [1:0] ready_s;
   logic [1:0][WIN_BITS-1:0] win_in_s;

   wire [1:0][3:0]          k_w;
   wire [1:0][3:0]          q_w;
   wire [1:0][WIN_BITS-1:0] win_out_w;
   wire [1:0]               valid_w;
   wire [1:0]               last_w;
   wire [1:0]               busy_w;
   wire [1:0]               done_w;
`ifdef WINDOW_SCANNER_PERF_EN
   wire [1:0][15:0]         perf_w;
`endif

   logic [7:0] fmap [IMG_DIM][IMG_DIM];
   exp_t exp_q [2][$];

   int unsigned n_tests;
   int unsigned n_fail;
   int unsigned pop_cnt     [2];
   int unsigned scans_done  [2];
   bit          pend_done   [2];
   bit          prev_stall  [2];
   logic [WIN_BITS-1:0] prev_out [2];
   logic [3:0]  prev_k [2];
   logic [3:0]  prev_q [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      window_scanner_if u_if ();
      assign u_if.win_ready = ready_s[g];
      assign win_out_w[g]   = u_if.win_out;
      assign valid_w[g]     = u_if.win_valid;
      assign last_w[g]      = u_if.win_last;

      window_scanner #(
         .STRIDE   ((g == 0) ? 1 : 3),
         .READ_LAT (1)
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .start   (start_s[g]),
         .k       (k_w[g]),
         .q       (q_w[g]),
         .win_in  (win_in_s[g]),
         .win     (u_if.master),
         .busy    (busy_w[g]),
         .done    (done_w[g])
`ifdef WINDOW_SCANNER_PERF_EN
         ,
         .perf_stall (perf_w[g])
`endif
      );
   end

   // Reference window: byte 4*i+j is fmap[k+i][q+j].
   function automatic logic [WIN_BITS-1:0] win_of(input int kk, input int qq);
      logic [WIN_BITS-1:0] w;
      w = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            w[(4*i+j)*8 +: 8] = fmap[kk+i][qq+j];
      return w;
   endfunction

   // Buffer model: one-cycle registered window read.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         win_in_s[i] <= win_of(int'(k_w[i]), int'(q_w[i]));
   end

   task automatic check(input string name, input logic [WIN_BITS-1:0] act,
                        input logic [WIN_BITS-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_fmap(input bit rnd);
      for (int r = 0; r < IMG_DIM; r++)
         for (int c = 0; c < IMG_DIM; c++)
            fmap[r][c] = rnd ? 8'($urandom) : 8'(13*r + c);
   endtask

   // Queue every window of one scan in row-major order.
   task automatic push_scan(input int i);
      int   s;
      exp_t e;
      s = (i == 0) ? 1 : 3;
      pop_cnt[i] = 0;
      for (int kk = 0; kk <= 9; kk += s)
         for (int qq = 0; qq <= 9; qq += s) begin
            e.k    = 4'(kk);
            e.q    = 4'(qq);
            e.last = (kk == 9) && (qq == 9);
            e.data = win_of(kk, qq);
            exp_q[i].push_back(e);
         end
   endtask

   task automatic check_reset(input int i);
      check($sformatf("d%0d rst k", i), k_w[i], 0);
      check($sformatf("d%0d rst q", i), q_w[i], 0);
      check($sformatf("d%0d rst win_out", i), win_out_w[i], 0);
      check($sformatf("d%0d rst win_valid", i), valid_w[i], 0);
      check($sformatf("d%0d rst win_last", i), last_w[i], 0);
      check($sformatf("d%0d rst busy", i), busy_w[i], 0);
      check($sformatf("d%0d rst done", i), done_w[i], 0);
`ifdef WINDOW_SCANNER_PERF_EN
      check($sformatf("d%0d rst perf_stall", i), perf_w[i], 0);
`endif
   endtask

   task automatic wait_window(input int i, input int idx);
      int n;
      n = 0;
      while (!(valid_w[i] && pop_cnt[i] == idx) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("d%0d reach window %0d", i, idx), pop_cnt[i], idx);
   endtask

   task automatic wait_scans(input int i, input int target);
      int n;
      n = 0;
      while (scans_done[i] < target && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("d%0d scans completed", i), scans_done[i], target);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            pend_done[i]  = 1'b0;
            prev_stall[i] = 1'b0;
         end else begin
            if (pend_done[i]) begin
               check($sformatf("d%0d done after last", i), done_w[i], 1);
               check($sformatf("d%0d busy in done", i), busy_w[i], 0);
               pend_done[i] = 1'b0;
               scans_done[i]++;
            end else if (done_w[i]) begin
               check($sformatf("d%0d unexpected done", i), done_w[i], 0);
            end
            if (prev_stall[i]) begin
               check($sformatf("d%0d stall valid", i), valid_w[i], 1);
               check($sformatf("d%0d stall win_out", i), win_out_w[i], prev_out[i]);
               check($sformatf("d%0d stall k", i), k_w[i], prev_k[i]);
               check($sformatf("d%0d stall q", i), q_w[i], prev_q[i]);
            end
            if (valid_w[i] && ready_s[i]) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("d%0d extra window", i), 1, 0);
               end else begin
                  exp_t e;
                  e = exp_q[i].pop_front();
                  check($sformatf("d%0d w%0d data", i, pop_cnt[i]), win_out_w[i], e.data);
                  check($sformatf("d%0d w%0d k", i, pop_cnt[i]), k_w[i], e.k);
                  check($sformatf("d%0d w%0d q", i, pop_cnt[i]), q_w[i], e.q);
                  check($sformatf("d%0d w%0d last", i, pop_cnt[i]), last_w[i], e.last);
                  if (e.last) pend_done[i] = 1'b1;
               end
               pop_cnt[i]++;
            end
            prev_stall[i] = valid_w[i] && !ready_s[i];
            prev_out[i]   = win_out_w[i];
            prev_k[i]     = k_w[i];
            prev_q[i]     = q_w[i];
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 2; i++) begin
         pop_cnt[i]    = 0;
         scans_done[i] = 0;
         pend_done[i]  = 1'b0;
         prev_stall[i] = 1'b0;
      end
      rst     = 1'b1;
      start_s = 2'b00;
      ready_s = 2'b11;
      fill_fmap(1'b0);

      // Reset, with a start pulse coincident with rst.
      repeat (2) @(posedge clk);
      #1 start_s = 2'b11;
      @(posedge clk);
      @(negedge clk);
      check_reset(0);
      check_reset(1);
      @(posedge clk); #1;
      rst     = 1'b0;
      start_s = 2'b00;
      @(negedge clk);
      check("d0 start under rst ignored", busy_w[0], 0);

      // Scan 1 on both: latency, backpressure on window 3, stray start.
      @(posedge clk); #1;
      push_scan(0);
      push_scan(1);
      start_s = 2'b11;
      @(posedge clk); #1;
      start_s = 2'b00;
      lat = 1;
      while (!valid_w[0] && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency start to win_valid", lat, 3);

      wait_window(0, 3);
      ready_s[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 ready_s[0] = 1'b1;

      wait_window(0, 20);
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;

      wait_scans(1, 1);
      wait_scans(0, 1);
`ifdef WINDOW_SCANNER_PERF_EN
      check("d0 perf_stall", perf_w[0], 5);
      check("d1 perf_stall", perf_w[1], 0);
`endif

      // Scan 2 back-to-back on d0: random map, random backpressure.
      fill_fmap(1'b1);
      push_scan(0);
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      begin
         int n;
         n = 0;
         while (scans_done[0] < 2 && n < 3000) begin
            ready_s[0] = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
         end
      end
      ready_s[0] = 1'b1;
      check("d0 random scan completed", scans_done[0], 2);

      // Scan 3 on d0: reset while holding window 40.
      fill_fmap(1'b0);
      @(posedge clk); #1;
      push_scan(0);
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      wait_window(0, 40);
      ready_s[0] = 1'b0;
      rst        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset(0);
      exp_q[0].delete();
      @(posedge clk); #1;
      rst        = 1'b0;
      ready_s[0] = 1'b1;
      @(negedge clk);
      check("d0 no done after abort", done_w[0], 0);

      // Restart both from k=q=0.
      @(posedge clk); #1;
      push_scan(0);
      push_scan(1);
      start_s = 2'b11;
      @(posedge clk); #1;
      start_s = 2'b00;
      wait_scans(1, 2);
      wait_scans(0, 3);

      check("d0 queue drained", exp_q[0].size(), 0);
      check("d1 queue drained", exp_q[1].size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/window_scanner.md
Name: window_scanner

Overview:
- Read-side controller for the 13x13 feature-map buffer.
- Sweeps the window offset (k,q) over every legal 4x4 window position in row-major order and captures the buffer's registered 16-byte window output.
- Presents each window to the downstream PE array over a valid/ready handshake.
- Pairs with the loader that fills the buffer through address/en/dataIn.

Parameters:
- IMG_DIM, 13, buffer side length in bytes.
- WIN, 4, window side length; window = WIN*WIN bytes.
- STRIDE, 1, step between window positions in both k and q. Legal values: 1 and 3. With these values (IMG_DIM-WIN) is divisible by STRIDE.
- DW, 8, byte width.
- READ_LAT, 1, buffer read latency in cycles, from k/q sampled to dataOut valid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a scan when idle.
- k  out  4  window row offset to buffer.
- q  out  4  window column offset to buffer.
- win_in  in  WIN*WIN*DW  buffer dataOut flattened; byte n at [n*DW +: DW], n=4*i+j.
- win_out  out  WIN*WIN*DW  captured window, same byte layout as win_in.
- win_valid  out  1  win_out holds a window not yet accepted.
- win_ready  in  1  downstream accepts when win_valid && win_ready.
- win_last  out  1  qualifies win_valid; set on the final window of the scan.
- busy  out  1  high from the first cycle after an accepted start until done.
- done  out  1  single-cycle pulse after the last window is accepted.

Behaviour:
- Reset values: k=0, q=0, win_out=0, win_valid=0, win_last=0, busy=0, done=0; state=IDLE.
- Reset mid-scan aborts immediately. No done pulse. Any window in flight is dropped.
- Positions per axis: NPOS=(IMG_DIM-WIN)/STRIDE+1. Gives 10 at STRIDE 1 and 4 at STRIDE 3.
- Position order: k outer, q inner, each stepping by STRIDE from 0 to IMG_DIM-WIN.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD, DONE.
  - IDLE: on start go to ISSUE with k=q=0 and busy=1.
  - ISSUE: k,q stable; stay READ_LAT cycles, tracked by a wait counter, so the buffer registers the window.
  - CAPTURE: win_in is valid this cycle; on the next edge latch it into win_out, set win_valid=1, and set win_last if (k,q)=(IMG_DIM-WIN, IMG_DIM-WIN). Go to HOLD.
  - HOLD: while win_ready=0, hold win_out, k, q and win_last stable. On handshake clear win_valid. If win_last, go to DONE; otherwise advance (q+=STRIDE, or q=0 and k+=STRIDE on row end) and go to ISSUE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- k and q change only on the HOLD handshake edge or on start. The buffer therefore never sees a transient offset.
- Latency:
  - start at cycle 0 gives win_valid at cycle 3 with READ_LAT=1.
  - Steady state with win_ready tied high: one window per 3 cycles (ISSUE, CAPTURE, HOLD).
- start while busy or in DONE is ignored. start coincident with rst is ignored.
- win_ready while win_valid=0 has no effect.
- Total windows per scan: NPOS*NPOS, i.e. 100 at STRIDE 1 and 16 at STRIDE 3.

Optional Feature:
- Macro: WINDOW_SCANNER_PERF_EN.
- When defined:
  - Adds output perf_stall 16 bits, which counts cycles with win_valid && !win_ready.
  - Saturates at 16'hFFFF.
  - Cleared on rst and on an accepted start; holds its value after done.
- When undefined: the port and counter are absent. Nothing else changes.

Decomposition:
- Package cnn_buf_pkg:
  - constants IMG_DIM=13, WIN=4, DW=8;
  - localparam NPOS function of STRIDE;
  - scanner state enum typedef {IDLE, ISSUE, CAPTURE, HOLD, DONE}.
  - The loader and buffer share the same geometry constants.
- Sub-module pos_counter_2d: stride-stepping k/q counter with inputs clr/adv and outputs k, q, at_last. Instantiated once.

Test Plan:
- Fill the buffer with byte[r][c]=(13*r+c)&8'hFF, STRIDE=1, win_ready=1, pulse start:
  - 100 windows emitted;
  - window 0 byte0=0 and byte15=42;
  - window at k=2,q=5 byte0=31;
  - win_last only on window 99 (k=q=9, byte15=168);
  - done one cycle after the last handshake.
- Backpressure: win_ready low for 5 cycles on window 3:
  - win_out, k=0, q=3 and win_valid all stable;
  - perf_stall=5 with WINDOW_SCANNER_PERF_EN defined;
  - no window skipped or duplicated.
- STRIDE=3: 16 windows, at (k,q) = (0,0),(0,3),(0,6),(0,9),(3,0),…,(9,9); last byte15=168.
- Pulse rst in HOLD of window 40:
  - all outputs return to reset values next cycle, no done;
  - a new start restarts from k=q=0.
- start pulsed while busy: ignored, scan order unaffected. Back-to-back scans: second start the cycle after done produces a full second sequence.
- Latency check, READ_LAT=1: start at cycle 0 gives win_valid first high at cycle 3.
